acc: RTL and testbench
======================

ACC -- requirements
Module: acc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data path width in bits; all behaviour below is stated for WIDTH = 8.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes occur on its rising edge except reset.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port wacc, input, 1 bit: accumulator write enable, active-high, sampled on the rising edge of clk.
REQ-005 The block SHALL have port in_data, input, WIDTH bits: value to load into the accumulator.
REQ-006 The block SHALL have port out_data, output, WIDTH bits: current accumulator contents.
REQ-007 The block SHALL have exactly one clock and one reset, and SHALL contain no other clock domains, latches or combinational feedback loops.

Function
REQ-008 The block SHALL hold one WIDTH-bit accumulator register, acc.
REQ-009 On a rising edge of clk with rst_n = 1 and wacc = 1, acc SHALL load in_data as an exact copy: no arithmetic, no sign change, no truncation.
REQ-010 On a rising edge of clk with rst_n = 1 and wacc = 0, acc SHALL keep its value.
REQ-011 out_data SHALL be driven directly from acc, with no combinational path from in_data or wacc to out_data.
REQ-012 Write latency SHALL be one cycle: a value loaded at edge N SHALL appear on out_data immediately after edge N and hold until the next load or reset.
REQ-013 Back-to-back writes (wacc held at 1) SHALL load a new value on every edge; the last edge wins.
REQ-014 Changes on in_data while wacc = 0 SHALL have no effect on out_data.
REQ-015 All WIDTH-bit values SHALL be stored and read back unchanged, including the boundaries 0x00, 0xFF and 0x80.
REQ-016 X or Z on in_data SHALL affect acc only when wacc = 1 at a clock edge.

Reset
REQ-017 While rst_n = 0, acc and out_data SHALL be 0x00, without waiting for a clock edge.
REQ-018 Reset SHALL take priority over wacc: a write coinciding with rst_n = 0 SHALL be discarded.
REQ-019 Reset asserted mid-operation SHALL clear acc immediately, discarding the held value.
REQ-020 After rst_n deasserts, the first rising edge with wacc = 1 SHALL load normally.
REQ-021 The testbench SHALL release rst_n away from the rising edge of clk; the design places no further recovery constraint on it.

Verification
REQ-022 Scenario: rst_n = 0 with wacc = 1 and in_data = 0x55 applied -> out_data = 0x00 with no clock edge required, and still 0x00 after several edges.
REQ-023 Scenario: after reset, wacc = 1, in_data = 159 (0x9F), one clock edge -> out_data = 0x9F after that edge and 0x00 before it.
REQ-024 Scenario: load 0x9F, then wacc = 0 and in_data cycled through 0x00, 0xFF, 0x12 over 3 edges -> out_data remains 0x9F.
REQ-025 Scenario: wacc = 1 with in_data = 0x01, 0xFF, 0x80, 0x00 on consecutive edges -> out_data follows each value with one-edge latency.
REQ-026 Scenario: load 0xA5, then pulse rst_n low between clock edges -> out_data becomes 0x00 asynchronously, and the next edge with wacc = 1 and in_data = 0x3C gives 0x3C.

Source files
------------

// File: rtl/acc.sv
// Single-register accumulator: loads in_data on a write-enabled clock edge,
// holds otherwise, and clears asynchronously while rst_n is low.
// out_data comes straight from the register, so there is no combinational
// path from the inputs to the output.
module acc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wacc,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;

    // Next-state select: take in_data only on a write, otherwise recirculate,
    // so unknown values on in_data cannot leak in while wacc is low.
    always_comb begin
        acc_d = acc_q;
        if (wacc) begin
            acc_d = in_data;
        end
    end

    // Accumulator register; the asynchronous reset overrides any write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign out_data = acc_q;

endmodule

// File: tb/tb_acc.sv
// Self-checking bench for acc: directed scenarios plus a randomized run
// compared against a "last value written" reference model.
module tb_acc;

   logic       clk;
   logic       rst_n;
   logic       wacc;
   logic [7:0] in_data;
   logic [7:0] out_data;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [7:0] model;

   acc #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wacc     (wacc),
      .in_data  (in_data),
      .out_data (out_data)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance past one rising edge and settle before sampling or driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      wacc    = 1'b1;
      in_data = 8'h55;
      #2;
      testsRun++;
      if (out_data !== 8'h00) begin
         testsFailed++;
         $display("[TB] FAIL reset_no_edge: got %h expected %h", out_data, 8'h00);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         testsRun++;
         if (out_data !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL reset_held_edge%0d: got %h expected %h", i, out_data, 8'h00);
         end
      end
      wacc = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model = 8'h00;
      #1;
   endtask

   task automatic test_load();
      wacc    = 1'b1;
      in_data = 8'h9F;
      testsRun++;
      if (out_data !== 8'h00) begin
         testsFailed++;
         $display("[TB] FAIL load_before_edge: got %h expected %h", out_data, 8'h00);
      end
      tick();
      testsRun++;
      if (out_data !== 8'h9F) begin
         testsFailed++;
         $display("[TB] FAIL load_after_edge: got %h expected %h", out_data, 8'h9F);
      end
      model = 8'h9F;
   endtask

   task automatic test_hold();
      logic [7:0] vals [3];
      vals[0] = 8'h00;
      vals[1] = 8'hFF;
      vals[2] = 8'h12;
      wacc = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_data = vals[i];
         tick();
         testsRun++;
         if (out_data !== 8'h9F) begin
            testsFailed++;
            $display("[TB] FAIL hold_%0d: got %h expected %h", i, out_data, 8'h9F);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] vals [4];
      logic [7:0] prev;
      vals[0] = 8'h01;
      vals[1] = 8'hFF;
      vals[2] = 8'h80;
      vals[3] = 8'h00;
      prev = model;
      wacc = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = vals[i];
         #1;
         testsRun++;
         if (out_data !== prev) begin
            testsFailed++;
            $display("[TB] FAIL b2b_pre_%0d: got %h expected %h", i, out_data, prev);
         end
         tick();
         testsRun++;
         if (out_data !== vals[i]) begin
            testsFailed++;
            $display("[TB] FAIL b2b_post_%0d: got %h expected %h", i, out_data, vals[i]);
         end
         prev = vals[i];
      end
      wacc  = 1'b0;
      model = prev;
   endtask

   task automatic test_async_reset();
      wacc    = 1'b1;
      in_data = 8'hA5;
      tick();
      testsRun++;
      if (out_data !== 8'hA5) begin
         testsFailed++;
         $display("[TB] FAIL areset_load: got %h expected %h", out_data, 8'hA5);
      end
      wacc = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      testsRun++;
      if (out_data !== 8'h00) begin
         testsFailed++;
         $display("[TB] FAIL areset_async: got %h expected %h", out_data, 8'h00);
      end
      wacc    = 1'b1;
      in_data = 8'h77;
      tick();
      testsRun++;
      if (out_data !== 8'h00) begin
         testsFailed++;
         $display("[TB] FAIL areset_priority: got %h expected %h", out_data, 8'h00);
      end
      @(negedge clk);
      rst_n   = 1'b1;
      in_data = 8'h3C;
      tick();
      testsRun++;
      if (out_data !== 8'h3C) begin
         testsFailed++;
         $display("[TB] FAIL areset_first_write: got %h expected %h", out_data, 8'h3C);
      end
      wacc  = 1'b0;
      model = 8'h3C;
   endtask

   task automatic test_x_ignored();
      wacc    = 1'b0;
      in_data = 8'bxxxx_zzzz;
      tick();
      testsRun++;
      if (out_data !== model) begin
         testsFailed++;
         $display("[TB] FAIL x_ignored: got %h expected %h", out_data, model);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         wacc = 1'($urandom_range(0, 1));
         if (!wacc && ($urandom_range(0, 7) == 0)) begin
            in_data = 8'bx;
         end else begin
            in_data = 8'($urandom);
         end
         if (wacc) begin
            model = in_data;
         end
         tick();
         testsRun++;
         if (out_data !== model) begin
            testsFailed++;
            $display("[TB] FAIL random_%0d: got %h expected %h", i, out_data, model);
         end
      end
      wacc = 1'b0;
   endtask

   // Run every scenario in order, then report.
   initial begin
      model = 8'h00;
      test_reset();
      test_load();
      test_hold();
      test_back_to_back();
      test_async_reset();
      test_x_ignored();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
